// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock-enable generator.
package clkdiv_pkg;

    localparam int CNT_W_DEF = 26;
    localparam int DIV_MIN   = 2;

    typedef enum logic {
        MODE_FREE    = 1'b0,
        MODE_ONESHOT = 1'b1
    } div_mode_t;

    // Channel-select width; a single channel still gets a one-bit select.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, tick/square generation, shadow config and
// the arm/apply logic that swaps divisors only on period boundaries.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(32'd50_000_000)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sync_clr_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  div_mode_t        cfg_mode_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    div_mode_t        mode_q, mode_d;
    div_mode_t        pend_mode_q, pend_mode_d;
    logic             armed_q, armed_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [CNT_W-1:0] count_inc_s;
    logic [CNT_W-1:0] half_s;
    logic             last_s;
    logic             apply_s;

    // half_s = ceil(div/2) without needing a wider adder
    assign count_inc_s = count_q + CNT_W'(1'b1);
    assign half_s      = (div_q >> 1) + CNT_W'(div_q[0]);
    assign last_s      = (count_q == (div_q - CNT_W'(1'b1)));

    // Next-state: sync_clr, then counting, then disarmed-apply; capture last
    always_comb begin
        count_d     = count_q;
        div_d       = div_q;
        mode_d      = mode_q;
        armed_d     = armed_q;
        pending_d   = pending_q;
        pend_div_d  = pend_div_q;
        pend_mode_d = pend_mode_q;
        tick_d      = 1'b0;
        sq_d        = sq_q;
        apply_s     = 1'b0;

        if (sync_clr_i) begin
            count_d = {CNT_W{1'b0}};
            sq_d    = 1'b1;
            armed_d = 1'b1;
            apply_s = pending_q;
        end else if (enable_i && armed_q) begin
            if (last_s) begin
                count_d = {CNT_W{1'b0}};
                tick_d  = 1'b1;
                sq_d    = 1'b1;
                if (pending_q) begin
                    apply_s = 1'b1;
                end else if (mode_q == MODE_ONESHOT) begin
                    armed_d = 1'b0;
                    sq_d    = 1'b0;
                end else begin
                    apply_s = 1'b0;
                end
            end else begin
                count_d = count_inc_s;
                sq_d    = (count_inc_s < half_s);
            end
        end else if (!armed_q) begin
            apply_s = pending_q;
        end else begin
            sq_d = sq_q;
        end

        // A freshly applied config always re-arms, even over a one-shot finish
        if (apply_s) begin
            div_d     = pend_div_q;
            mode_d    = pend_mode_q;
            pending_d = 1'b0;
            armed_d   = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (cfg_we_i) begin
            pending_d   = 1'b1;
            pend_div_d  = cfg_div_i;
            pend_mode_d = cfg_mode_i;
        end else begin
            pend_div_d  = pend_div_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_q     <= {CNT_W{1'b0}};
            div_q       <= DIV_DEFAULT;
            mode_q      <= MODE_FREE;
            armed_q     <= 1'b1;
            pending_q   <= 1'b0;
            pend_div_q  <= DIV_DEFAULT;
            pend_mode_q <= MODE_FREE;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
        end else begin
            count_q     <= count_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            pend_div_q  <= pend_div_d;
            pend_mode_q <= pend_mode_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock-enable generator: config decode, ready
// mux and illegal-divisor reporting around CH independent channels.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DIV_DEFAULT = 32'd50_000_000,
    localparam int         CH_W        = ch_idx_w(CH)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             sync_clr_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_mode_i,
    output logic             cfg_err_o,
    output logic [CH-1:0]    tick_o,
    output logic [CH-1:0]    sq_o
);

    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH);

    logic [CH-1:0] pending_s;
    logic [CH-1:0] cfg_we_s;
    logic          ch_ok_s;
    logic          legal_s;
    logic          xfer_s;
    logic          cfg_ready_s;
    logic          cfg_err_q, cfg_err_d;

    // Ready/transfer decode; out-of-range channels are accepted and dropped
    always_comb begin
        ch_ok_s     = ({1'b0, cfg_ch_i} < CH_LIM);
        cfg_ready_s = 1'b1;
        if (ch_ok_s) begin
            cfg_ready_s = ~pending_s[cfg_ch_i];
        end else begin
            cfg_ready_s = 1'b1;
        end
        legal_s   = (cfg_div_i >= CNT_W'(DIV_MIN));
        xfer_s    = cfg_valid_i & cfg_ready_s;
        cfg_err_d = xfer_s & ~legal_s;
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        assign cfg_we_s[g] = xfer_s & legal_s & ch_ok_s & (cfg_ch_i == CH_W'(g));

        clkdiv_channel #(
            .CNT_W      (CNT_W),
            .DIV_DEFAULT(CNT_W'(DIV_DEFAULT))
        ) u_channel (
            .clock_i   (clock_i),
            .reset_i   (reset_i),
            .enable_i  (enable_i),
            .sync_clr_i(sync_clr_i),
            .cfg_we_i  (cfg_we_s[g]),
            .cfg_div_i (cfg_div_i),
            .cfg_mode_i(div_mode_t'(cfg_mode_i)),
            .tick_o    (tick_o[g]),
            .sq_o      (sq_o[g]),
            .pending_o (pending_s[g])
        );
    end

    // Rejected-divisor pulse register
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ready_o = cfg_ready_s;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider: vector table, behavioural
// scoreboard model and hand-written corner-case sequences.
module tb_prog_clock_divider;

    localparam int CH      = 4;
    localparam int CNT_W   = 26;
    localparam int DIV_DEF = 5;

    logic             clock = 1'b0;
    logic             rst_n, en, sclr, cv, cmode;
    logic [1:0]       cch;
    logic [CNT_W-1:0] cdiv;
    logic             crdy, cerr;
    logic [CH-1:0]    tick, sq;

    always #5 clock = ~clock;

    prog_clock_divider #(.CH(CH), .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF)) dut (
        .clock_i(clock), .reset_i(rst_n), .enable_i(en), .sync_clr_i(sclr),
        .cfg_valid_i(cv), .cfg_ready_o(crdy), .cfg_ch_i(cch), .cfg_div_i(cdiv),
        .cfg_mode_i(cmode), .cfg_err_o(cerr), .tick_o(tick), .sq_o(sq)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cn     = 0;
    logic [CH-1:0] tick_log [0:255];
    logic [CH-1:0] sq_log   [0:255];

    typedef struct { logic [CH-1:0] tick; logic [CH-1:0] sq; logic err; } exp_t;
    exp_t sb[$];

    typedef struct { bit rst_n; bit en; bit sclr; logic [CH-1:0] etick; logic [CH-1:0] esq; } vec_t;
    vec_t tbl[13];

    // behavioural reference model
    int m_cnt[CH], m_div[CH], m_pdiv[CH];
    bit m_mode[CH], m_pmode[CH], m_armed[CH], m_pend[CH], m_tick[CH], m_sq[CH];
    bit m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cn, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_div[c] = DIV_DEF; m_mode[c] = 1'b0; m_armed[c] = 1'b1;
            m_pend[c] = 1'b0; m_pdiv[c] = DIV_DEF; m_pmode[c] = 1'b0;
            m_tick[c] = 1'b0; m_sq[c] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_apply(input int c);
        m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pend[c] = 1'b0; m_armed[c] = 1'b1;
    endtask

    function automatic bit m_ready();
        return !m_pend[cch];
    endfunction

    task automatic model_step();
        bit xfer, legal;
        if (!rst_n) begin
            m_reset();
            return;
        end
        xfer  = cv && m_ready();
        legal = (cdiv >= 2);
        for (int c = 0; c < CH; c++) begin
            m_tick[c] = 1'b0;
            if (sclr) begin
                m_cnt[c] = 0; m_sq[c] = 1'b1; m_armed[c] = 1'b1;
                if (m_pend[c]) m_apply(c);
            end else if (en && m_armed[c]) begin
                if (m_cnt[c] == m_div[c] - 1) begin
                    m_cnt[c] = 0; m_tick[c] = 1'b1; m_sq[c] = 1'b1;
                    if (m_pend[c]) m_apply(c);
                    else if (m_mode[c]) begin m_armed[c] = 1'b0; m_sq[c] = 1'b0; end
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                    m_sq[c]  = (2 * m_cnt[c] < m_div[c]);
                end
            end else if (!m_armed[c] && m_pend[c]) begin
                m_apply(c);
            end
            if (xfer && legal && (int'(cch) == c)) begin
                m_pend[c] = 1'b1; m_pdiv[c] = int'(cdiv); m_pmode[c] = cmode;
            end
        end
        m_err = xfer && !legal;
    endtask

    // one clock: check ready, push model expectation, clock, pop and compare
    task automatic cyc();
        exp_t e;
        #1;
        chk("cfg_ready", crdy, m_ready());
        model_step();
        for (int c = 0; c < CH; c++) begin
            e.tick[c] = m_tick[c];
            e.sq[c]   = m_sq[c];
        end
        e.err = m_err;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (rst_n) begin
            cn++;
            if (cn < 256) begin
                tick_log[cn] = tick;
                sq_log[cn]   = sq;
            end
        end
        e = sb.pop_front();
        chk("sb_tick", tick, e.tick);
        chk("sb_sq", sq, e.sq);
        chk("sb_cfg_err", cerr, e.err);
    endtask

    function automatic int count_ticks(input int c, input int a, input int b);
        int n = 0;
        for (int t = a; t <= b; t++) n += int'(tick_log[t][c]);
        return n;
    endfunction

    function automatic int count_sq(input int c, input int a, input int b);
        int n = 0;
        for (int t = a; t <= b; t++) n += int'(sq_log[t][c]);
        return n;
    endfunction

    task automatic apply_table();
        cn = 0;
        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en; sclr = tbl[i].sclr; cv = 1'b0;
            cyc();
            chk("tbl_tick", tick, tbl[i].etick);
            chk("tbl_sq", sq, tbl[i].esq);
            if (!tbl[i].rst_n) chk("tbl_reset_ready", crdy, 1);
        end
    endtask

    logic [CH-1:0] sq_hold;

    initial begin
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 4'hF, 4'hF};

        rst_n = 1'b0; en = 1'b1; sclr = 1'b0; cv = 1'b0; cch = 2'd0;
        cdiv = 26'd0; cmode = 1'b0;
        @(posedge clock);
        #1;
        m_reset();

        apply_table();                           // cn = 10, all channels at count 0

        // runtime reprogram of ch0 mid-period
        cyc(); cyc();                            // ch0 count = 2
        cv = 1'b1; cch = 2'd0; cdiv = 26'd8; cmode = 1'b0;
        #1 chk("ch0_ready_idle", crdy, 1);
        cyc();                                   // edge 13: accepted
        cdiv = 26'd6;
        #1 chk("ch0_ready_pending", crdy, 0);
        cyc();                                   // edge 14: stalled
        cch = 2'd1; cdiv = 26'd3; cmode = 1'b1;
        #1 chk("ch1_ready_while_ch0_pending", crdy, 1);
        cyc();                                   // edge 15: ch1 one-shot captured
        cv = 1'b0; cmode = 1'b0;
        repeat (30) cyc();                       // cn = 45
        chk("ch0_tick15", count_ticks(0, 15, 15), 1);
        chk("ch0_quiet_11_14", count_ticks(0, 11, 14), 0);
        chk("ch0_quiet_16_22", count_ticks(0, 16, 22), 0);
        chk("ch0_tick23", count_ticks(0, 23, 23), 1);
        chk("ch0_quiet_24_30", count_ticks(0, 24, 30), 0);
        chk("ch0_tick31", count_ticks(0, 31, 31), 1);
        chk("ch1_tick20_apply", count_ticks(1, 20, 20), 1);
        chk("ch1_oneshot_tick23", count_ticks(1, 21, 23), 1);
        chk("ch1_oneshot_silent", count_ticks(1, 24, 45), 0);
        chk("ch1_oneshot_sq_low", count_sq(1, 23, 45), 0);

        // sync_clr re-arms the one-shot
        sclr = 1'b1; cyc(); sclr = 1'b0;         // edge 46
        chk("sclr_sq_all_high", sq, 4'hF);
        repeat (4) cyc();                        // cn = 50
        chk("ch1_rearm_tick49", count_ticks(1, 47, 50), 1);
        chk("ch1_rearm_tick_at49", count_ticks(1, 49, 49), 1);

        // illegal divisors on ch2
        cv = 1'b1; cch = 2'd2; cdiv = 26'd1;
        cyc();
        chk("err_div1", cerr, 1);
        cdiv = 26'd0;
        cyc();
        chk("err_div0", cerr, 1);
        cv = 1'b0;
        cyc();
        chk("err_clears", cerr, 0);
        repeat (9) cyc();                        // cn = 62
        chk("ch2_tick56", count_ticks(2, 56, 56), 1);
        chk("ch2_quiet_57_60", count_ticks(2, 57, 60), 0);
        chk("ch2_tick61", count_ticks(2, 61, 61), 1);

        // phase alignment: ch2 div 4, ch3 div 6, applied by sync_clr
        cv = 1'b1; cch = 2'd2; cdiv = 26'd4; cyc();
        cch = 2'd3; cdiv = 26'd6; cyc();
        cv = 1'b0; sclr = 1'b1; cyc(); sclr = 1'b0;   // edge 65
        chk("align_sq_high", sq[3:2], 2'b11);
        chk("align_ch3_applied_ready", crdy, 1);
        repeat (25) cyc();                       // cn = 90
        chk("ch2_tick69", count_ticks(2, 66, 69), 1);
        chk("ch3_tick71", count_ticks(3, 66, 71), 1);
        chk("coincide77", int'(tick_log[77][2] & tick_log[77][3]), 1);
        chk("coincide89", int'(tick_log[89][2] & tick_log[89][3]), 1);
        chk("no_coincide_78_88", count_ticks(3, 78, 82) + count_ticks(3, 84, 88), 0);

        // enable hold for 7 cycles
        sq_hold = sq;
        en = 1'b0;
        repeat (7) begin
            cyc();
            chk("hold_sq", sq, sq_hold);
            chk("hold_tick", tick, 4'h0);
        end
        en = 1'b1;
        repeat (8) cyc();                        // cn = 105
        chk("ch2_stretched_quiet", count_ticks(2, 90, 99), 0);
        chk("ch2_stretched_tick100", count_ticks(2, 100, 100), 1);
        chk("ch3_stretched_quiet", count_ticks(3, 90, 101), 0);
        chk("ch3_stretched_tick102", count_ticks(3, 102, 102), 1);
        chk("ch1_oneshot_done", count_ticks(1, 69, 105), 0);

        // reset mid-operation with ch0 pending and ch1 idle
        cv = 1'b1; cch = 2'd0; cdiv = 26'd7; cyc();
        cv = 1'b0;
        #1 chk("ch0_pending_before_reset", crdy, 0);
        apply_table();
        for (int c = 0; c < CH; c++) begin
            cch = 2'(c);
            #1 chk("post_reset_ready", crdy, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel, runtime-programmable clock-enable generator for the 50 MHz system clock. It replaces fixed cascaded divider chains with CH independent counters. Each counter produces a one-cycle tick and a near-50% square wave at clock/div. Downstream logic stays on the single system clock and qualifies with tick; no derived clocks are created. It also adds a safe runtime reprogramming handshake, one-shot mode, and global phase alignment.

## Interface
- CH, 4, number of channels (1..16)
- CNT_W, 26, counter/divisor width
- DIV_DEFAULT, 50_000_000, divisor loaded into every channel at reset (1 Hz tick)
- clock  in  1  system clock, 50 MHz, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  global count enable; low = all counters hold
- sync_clr  in  1  restart all channels in phase
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept (combinational)
- cfg_ch  in  $clog2(CH) (min 1)  target channel
- cfg_div  in  CNT_W  new divisor; legal 2..2^CNT_W-1
- cfg_mode  in  1  0 = free-running, 1 = one-shot
- cfg_err  out  1  one-cycle pulse: illegal divisor rejected
- tick  out  CH  one-cycle pulse per period, per channel
- sq  out  CH  square output, per channel

## Operation
- Per channel state: count[CNT_W], div, mode, armed, pending, pend_div, pend_mode.
- Reset (reset==0 at edge):
  - count=0, div=DIV_DEFAULT, mode=free, armed=1, pending=0
  - tick=0, sq=0, cfg_err=0
- Priority each edge: reset > sync_clr > counting.
- Counting (enable=1, armed=1):
  - if count==div-1: count_next=0, tick<=1; else count_next=count+1, tick<=0.
  - sq<=(count_next < ceil(div/2)).
- Square duty: high ceil(div/2) cycles, low floor(div/2) cycles. sq rises on the same edge tick asserts.
- enable=0: count and sq hold, tick<=0.
- armed=0: count and sq hold, tick<=0.
- One-shot: on the wrap edge the channel ticks once, then armed<=0 and sq<=0. It stays idle until sync_clr or a new config is applied.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch].
  - Transfer occurs when cfg_valid & cfg_ready.
  - If cfg_div<2: nothing stored, cfg_err<=1 next cycle. The transfer still completes.
  - Otherwise: pending<=1, pend_div/pend_mode captured.
- Pending apply: div/mode<=pend, pending<=0, armed<=1. This happens at the first of:
  - the channel's wrap edge (count==div-1 with enable);
  - a sync_clr edge;
  - the next edge while the channel is disarmed.
- No partial period ever uses a mixed divisor.
- sync_clr:
  - all count<=0, tick<=0
  - sq<=1 (count_next = 0, which is always < ceil(div/2) for div ≥ 2)
  - armed<=1, pending configs applied
  - acts regardless of enable
- A config transfer in the same cycle as sync_clr is captured as pending and applied at the following wrap.

## Timing
- Latency: with enable held from the first edge after reset release, the first tick asserts in the cycle after the div-th enabled edge.
- Ticks then repeat every div enabled cycles.
- div=2: tick every second cycle; sq alternates 1,0.
- Counter never exceeds div-1. Comparison uses div-1 at CNT_W width; no wrap beyond 2^CNT_W-1.
- cfg_err: one cycle, the edge after the rejected transfer.
- All outputs are registered except cfg_ready.

## Structure
- Package clkdiv_pkg:
  - localparam CNT_W_DEF
  - enum div_mode_t {MODE_FREE, MODE_ONESHOT}
  - DIV_MIN = 2
- Sub-module clkdiv_channel: one counter, shadow registers, and arm/apply logic; instantiated CH times.
- Top level: cfg_ch decode, cfg_ready mux, cfg_err register.

## Test plan
- Reset values: hold reset low 3 cycles with enable=1 → tick=0, sq=0, cfg_ready=1. With DIV_DEFAULT overridden to 5, the first tick arrives 5 enabled cycles after release, then every 5. sq pattern after each tick: 1,1,1,0,0.
- Runtime reprogram, ch0: mid-period (count=2, div=5) program div=8 → cfg_ready[ch0] low until the wrap. The next period is exactly 8 cycles, the one before it exactly 5. A second request to ch0 while pending stalls; ch1 is accepted.
- One-shot: program ch1 div=3 mode=1 → one tick 3 cycles later, then tick/sq stay 0 for 20 cycles. sync_clr re-arms, and a tick follows 3 cycles later.
- Illegal divisor: cfg_div=1 and cfg_div=0 → cfg_err pulses 1 cycle each; channel period unchanged.
- Phase alignment and hold: channels with div 4 and 6 run, then sync_clr → both counts are 0 and sq=1. Ticks coincide every 12 cycles. Dropping enable for 7 cycles freezes count/sq and stretches the period by exactly 7.
- Reset mid-operation: assert reset with ch0 pending and ch1 one-shot done → all channels return to DIV_DEFAULT, free mode, armed, with pending cleared.
